// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings
// and the sequencing FSM state type.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per RUN cycle on operand magnitudes.
//
// state | meaning
// IDLE  | waiting for Start; HI/LO writable via HiWrite/LoWrite
// RUN   | WIDTH iteration steps on the latched magnitudes
// FIX   | sign correction, HI/LO load at exit, Done the cycle after
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] oper;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             in_div;
    logic             in_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             launch;
    logic             dbz;
    logic             go;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     mul_part;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               finish;

    // Launch decode; magnitudes are taken here so RUN is purely unsigned.
    always_comb begin
        in_div    = Op[1];
        in_signed = SIGNED_EN && !Op[0];
        mag_a     = (in_signed && A[WIDTH-1]) ? -A : A;
        mag_b     = (in_signed && B[WIDTH-1]) ? -B : B;
        launch    = (state == IDLE) && Start && !Flush;
        dbz       = launch && in_div && (B == '0);
        go        = launch && !dbz;
        finish    = (state == FIX) && !Flush;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = RUN;
            RUN: begin
                if (Flush) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != IDLE);
    end

    // Step arithmetic. The remainder stays below the divisor, so diff[WIDTH]
    // is exactly the restoring-divide borrow.
    always_comb begin
        add_sum  = {1'b0, acc_hi} + {1'b0, oper};
        mul_part = acc_lo[0] ? add_sum : {1'b0, acc_hi};
        shifted  = {acc_hi, acc_lo[WIDTH-1]};
        diff     = shifted - {1'b0, oper};
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            oper   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (go) begin
            cnt    <= '0;
            op_div <= in_div;
            neg_q  <= in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= in_signed && A[WIDTH-1];
            acc_hi <= '0;
            if (in_div) begin
                oper   <= mag_b;
                acc_lo <= mag_a;
            end else begin
                oper   <= mag_a;
                acc_lo <= mag_b;
            end
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            if (op_div) begin
                acc_hi <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                {acc_hi, acc_lo} <= {mul_part, acc_lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        if (op_div) begin
            res_lo = neg_q ? -acc_lo : acc_lo;
            res_hi = neg_r ? -acc_hi : acc_hi;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            Done      <= finish || dbz;
            DivByZero <= dbz;
            if (finish) begin
                Hi <= res_hi;
                Lo <= res_lo;
            end else if (state == IDLE) begin
                if (HiWrite) Hi <= WrData;
                if (LoWrite) Lo <= WrData;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32: a vector table for results and
// latency, plus hand-written sequences for flush, reset, busy and MTHI/MTLO cases.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        HiWrite;
    logic        LoWrite;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Flush     (Flush),
        .HiWrite   (HiWrite),
        .LoWrite   (LoWrite),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start is sampled at the edge ending cycle 0; returns at cycle 1.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat, output bit busy_ok);
        lat     = from;
        busy_ok = 1'b1;
        while (!Done && lat < 80) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (Busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (Done === 1'b1) cnt++;
        end
    endtask

    task automatic write_hilo(input bit hi_sel, input logic [31:0] data);
        WrData = data;
        if (hi_sel) HiWrite = 1'b1;
        else        LoWrite = 1'b1;
        step();
        HiWrite = 1'b0;
        LoWrite = 1'b0;
    endtask

    initial begin
        int  lat;
        int  nd;
        bit  bok;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[4]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[5]  = '{OP_MULT,  32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
        vecs[6]  = '{OP_MULTU, 32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000};
        vecs[7]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[9]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[12] = '{OP_DIVU,  32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000};
        vecs[13] = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000007, 32'h00000004, 32'h24924923};

        Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        Flush = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; WrData = '0;
        #2 Rst = 1'b0;
        #10;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'({Done, DivByZero}), 64'd0);
        check("reset_hilo", {Hi, Lo}, 64'd0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1, lat, bok);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
            check($sformatf("vec%0d_hilo", i), {Hi, Lo}, {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d_dbz", i), 64'(DivByZero), 64'd0);
            step();
            check($sformatf("vec%0d_done_pulse", i), 64'(Done), 64'd0);
        end

        // Start while busy is dropped; operand changes mid-run have no effect.
        launch(OP_MULT, 32'hFFFFFFFD, 32'h00000005);
        repeat (4) step();
        Op = OP_DIVU; A = 32'd100; B = 32'd7; Start = 1'b1;
        step();
        Start = 1'b0; A = 32'h0BADF00D; B = 32'h00000000;
        wait_done(6, lat, bok);
        check("busy_start_latency", 64'(lat), 64'd34);
        check("busy_start_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);
        count_done(40, nd);
        check("busy_start_not_queued", 64'(nd), 64'd0);

        // Flush during RUN at cycle 10.
        write_hilo(1'b1, 32'hAAAA5555);
        write_hilo(1'b0, 32'h12345678);
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_run_busy", 64'(Busy), 64'd0);
        count_done(40, nd);
        check("flush_run_no_done", 64'(nd), 64'd0);
        check("flush_run_hilo", {Hi, Lo}, 64'hAAAA5555_12345678);

        // Flush during FIX (cycle 33).
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (32) step();
        check("fix_busy", 64'(Busy), 64'd1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_fix_done", 64'({Done, Busy}), 64'd0);
        count_done(40, nd);
        check("flush_fix_no_done", 64'(nd), 64'd0);
        check("flush_fix_hilo", {Hi, Lo}, 64'hAAAA5555_12345678);

        // Flush has priority over Start in IDLE.
        Op = OP_MULT; A = 32'd3; B = 32'd3; Start = 1'b1; Flush = 1'b1;
        step();
        Start = 1'b0; Flush = 1'b0;
        check("flush_prio_busy", 64'(Busy), 64'd0);
        count_done(40, nd);
        check("flush_prio_no_done", 64'(nd), 64'd0);

        // MTLO in the Done cycle overwrites the fresh result.
        launch(OP_MULTU, 32'h12345678, 32'h00000010);
        wait_done(1, lat, bok);
        check("mtlo_done_latency", 64'(lat), 64'd34);
        write_hilo(1'b0, 32'hCAFEF00D);
        check("mtlo_done_hilo", {Hi, Lo}, 64'h00000001_CAFEF00D);

        // Divide by zero after MTHI.
        write_hilo(1'b1, 32'h00001234);
        check("mthi", 64'(Hi), 64'h1234);
        launch(OP_DIV, 32'd55, 32'd0);
        check("dbz_flags", 64'({Done, DivByZero, Busy}), 64'b110);
        check("dbz_hilo", {Hi, Lo}, 64'h00001234_CAFEF00D);
        step();
        check("dbz_pulse", 64'({Done, DivByZero}), 64'd0);

        // HiWrite ignored while busy; reset at cycle 20 of DIVU.
        launch(OP_DIVU, 32'd100, 32'd7);
        step();
        WrData = 32'hDEADBEEF; HiWrite = 1'b1;
        step();
        HiWrite = 1'b0;
        check("mthi_busy_ignored", 64'(Hi), 64'h1234);
        repeat (17) step();
        Rst = 1'b0;
        #1;
        check("midop_reset_hilo", {Hi, Lo}, 64'd0);
        check("midop_reset_busy", 64'({Busy, Done}), 64'd0);
        step();
        Rst = 1'b1;
        count_done(40, nd);
        check("midop_reset_no_done", 64'(nd), 64'd0);
        check("midop_reset_idle", 64'(Busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
